// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Opcodes, FSM state encodings and datapath select codes shared
//               by the multicycle and pipelined RISC-V control paths.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_main_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_main_fsm_if
// Description : Control bundle between the multicycle main FSM (master) and
//               the shared-memory datapath (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_main_fsm_if;

    logic [6:0] Op;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       IllegalOp;
    logic [3:0] StateDbg;

    modport master (
        input  Op, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, IllegalOp, StateDbg
    );

    modport slave (
        output Op, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, IllegalOp, StateDbg
    );

endinterface
`default_nettype wire

// File: rtl/imm_src_decoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_src_decoder
// Description : Opcode to immediate-format select, plus supported-opcode flag
//               honouring the optional instruction classes.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_src_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int ENABLE_ITYPE = 1,
    parameter int ENABLE_JAL   = 1
) (
    input  wire logic [6:0] i_op,
    output logic      [1:0] o_imm_src,
    output logic            o_supported
);

    localparam logic c_en_itype = (ENABLE_ITYPE != 0);
    localparam logic c_en_jal   = (ENABLE_JAL != 0);

    always_comb begin
        o_imm_src   = IMM_I;
        o_supported = 1'b0;
        case (i_op)
            OP_LOAD, OP_RTYPE: o_supported = 1'b1;
            OP_ITYPE:          o_supported = c_en_itype;
            OP_STORE: begin
                o_imm_src   = IMM_S;
                o_supported = 1'b1;
            end
            OP_BRANCH: begin
                o_imm_src   = IMM_B;
                o_supported = 1'b1;
            end
            // J-format select is reported even when jal is disabled
            OP_JAL: begin
                o_imm_src   = IMM_J;
                o_supported = c_en_jal;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_main_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_main_fsm
// Description : Moore control FSM for the multicycle RISC-V core with
//               configurable memory wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_STATES = 0,
    parameter int ENABLE_ITYPE    = 1,
    parameter int ENABLE_JAL      = 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    multicycle_main_fsm_if.master bus
);

    localparam logic [3:0] c_wait_last = 4'(MEM_WAIT_STATES);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_cnt_next;
    logic       w_wait_done;
    logic       w_supported;
    logic [1:0] w_imm_src;

    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_illegal;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;

    imm_src_decoder #(
        .ENABLE_ITYPE (ENABLE_ITYPE),
        .ENABLE_JAL   (ENABLE_JAL)
    ) u_imm_src_decoder (
        .i_op        (bus.Op),
        .o_imm_src   (w_imm_src),
        .o_supported (w_supported)
    );

    assign w_wait_done = (r_wait_cnt == c_wait_last);

    // Counter runs only while a memory state is being held; any exit clears it
    assign w_wait_cnt_next = (is_mem_state(r_state) && !w_wait_done)
                           ? r_wait_cnt + 4'd1 : 4'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        w_result_src = RES_ALUOUT;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_RD2;
        w_alu_op     = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                if (w_wait_done) begin
                    w_ir_write   = 1'b1;
                    w_pc_update  = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_a  = SRCA_OLDPC;
                w_alu_src_b  = SRCB_IMM;
                w_next_state = S_FETCH;
                if (!w_supported) begin
                    w_illegal = 1'b1;
                end else begin
                    case (bus.Op)
                        OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                        OP_RTYPE:          w_next_state = S_EXECUTER;
                        OP_ITYPE:          w_next_state = S_EXECUTEI;
                        OP_BRANCH:         w_next_state = S_BEQ;
                        OP_JAL:            w_next_state = S_JAL;
                        default:           w_next_state = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                w_alu_src_a  = SRCA_RD1;
                w_alu_src_b  = SRCB_IMM;
                w_next_state = (bus.Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                if (w_wait_done) w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (w_wait_done) w_next_state = S_FETCH;
            end
            S_EXECUTER: begin
                w_alu_src_a  = SRCA_RD1;
                w_alu_src_b  = SRCB_RD2;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alu_src_a  = SRCA_RD1;
                w_alu_src_b  = SRCB_IMM;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                w_alu_src_a  = SRCA_RD1;
                w_alu_src_b  = SRCB_RD2;
                w_alu_op     = ALUOP_SUB;
                w_branch     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a  = SRCA_OLDPC;
                w_alu_src_b  = SRCB_FOUR;
                w_pc_update  = 1'b1;
                w_next_state = S_ALUWB;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    // Register enables are forced off combinationally while reset is held
    assign bus.PCWrite   = rst & (w_pc_update | (w_branch & bus.Zero));
    assign bus.IRWrite   = rst & w_ir_write;
    assign bus.AdrSrc    = w_adr_src;
    assign bus.MemWrite  = w_mem_write;
    assign bus.RegWrite  = w_reg_write;
    assign bus.ResultSrc = w_result_src;
    assign bus.ALUSrcA   = w_alu_src_a;
    assign bus.ALUSrcB   = w_alu_src_b;
    assign bus.ALUOp     = w_alu_op;
    assign bus.ImmSrc    = w_imm_src;
    assign bus.IllegalOp = w_illegal;
    assign bus.StateDbg  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_main_fsm
// Description : Self-checking bench; three DUT configurations against a
//               per-instruction cycle-sequence reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_fsm;
    import riscv_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aop;
        logic [1:0] imm;
        logic       ill;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_main_fsm_if if0();
    multicycle_main_fsm_if if2();
    multicycle_main_fsm_if ifn();

    multicycle_main_fsm #(.MEM_WAIT_STATES(0)) u_w0 (.clk(clk), .rst(rst), .bus(if0.master));
    multicycle_main_fsm #(.MEM_WAIT_STATES(2)) u_w2 (.clk(clk), .rst(rst), .bus(if2.master));
    multicycle_main_fsm #(.MEM_WAIT_STATES(0), .ENABLE_ITYPE(0), .ENABLE_JAL(0))
        u_noi (.clk(clk), .rst(rst), .bus(ifn.master));

    rec_t o0, o2, on, obs;
    assign o0 = {if0.StateDbg, if0.PCWrite, if0.AdrSrc, if0.MemWrite, if0.IRWrite, if0.RegWrite,
                 if0.ResultSrc, if0.ALUSrcA, if0.ALUSrcB, if0.ALUOp, if0.ImmSrc, if0.IllegalOp};
    assign o2 = {if2.StateDbg, if2.PCWrite, if2.AdrSrc, if2.MemWrite, if2.IRWrite, if2.RegWrite,
                 if2.ResultSrc, if2.ALUSrcA, if2.ALUSrcB, if2.ALUOp, if2.ImmSrc, if2.IllegalOp};
    assign on = {ifn.StateDbg, ifn.PCWrite, ifn.AdrSrc, ifn.MemWrite, ifn.IRWrite, ifn.RegWrite,
                 ifn.ResultSrc, ifn.ALUSrcA, ifn.ALUSrcB, ifn.ALUOp, ifn.ImmSrc, ifn.IllegalOp};

    int sel = 0;   // 0: W=0, 1: W=2, 2: W=0 with I-type and jal disabled
    assign obs = (sel == 1) ? o2 : (sel == 2) ? on : o0;

    int   total = 0;
    int   bad   = 0;
    rec_t exp_q[$];

    function automatic rec_t mk(input logic [3:0] st, input logic pcw, adr, memw, irw, regw,
                                input logic [1:0] res, sa, sb, aop, imm, input logic ill);
        return {st, pcw, adr, memw, irw, regw, res, sa, sb, aop, imm, ill};
    endfunction

    // Expected per-cycle outputs of one whole instruction, starting at its first FETCH cycle
    task automatic model(input logic [6:0] op, input logic z);
        int         w;
        bit         ei, ej, sup;
        logic [1:0] imm;
        w   = (sel == 1) ? 2 : 0;
        ei  = (sel != 2);
        ej  = (sel != 2);
        imm = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 :
              (op == 7'b1101111) ? 2'b11 : 2'b00;
        sup = (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
              (op == 7'b1100011) || (op == 7'b0010011 && ei) || (op == 7'b1101111 && ej);
        exp_q.delete();
        for (int i = 0; i < w; i++)
            exp_q.push_back(mk(S_FETCH, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0));
        exp_q.push_back(mk(S_FETCH, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0));
        exp_q.push_back(mk(S_DECODE, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, !sup));
        if (!sup) return;
        case (op)
            7'b0000011: begin
                exp_q.push_back(mk(S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 0));
                for (int i = 0; i <= w; i++)
                    exp_q.push_back(mk(S_MEMREAD, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0));
                exp_q.push_back(mk(S_MEMWB, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, imm, 0));
            end
            7'b0100011: begin
                exp_q.push_back(mk(S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 0));
                for (int i = 0; i <= w; i++)
                    exp_q.push_back(mk(S_MEMWRITE, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0));
            end
            7'b0110011: begin
                exp_q.push_back(mk(S_EXECUTER, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, imm, 0));
                exp_q.push_back(mk(S_ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0));
            end
            7'b0010011: begin
                exp_q.push_back(mk(S_EXECUTEI, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, imm, 0));
                exp_q.push_back(mk(S_ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0));
            end
            7'b1100011:
                exp_q.push_back(mk(S_BEQ, z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, imm, 0));
            default: begin
                exp_q.push_back(mk(S_JAL, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, imm, 0));
                exp_q.push_back(mk(S_ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0));
            end
        endcase
    endtask

    task automatic set_in(input logic [6:0] op, input logic z);
        if0.Op = op; if2.Op = op; ifn.Op = op;
        if0.Zero = z; if2.Zero = z; ifn.Zero = z;
        #1;
    endtask

    // Leaves every DUT in its first FETCH cycle, between clock edges
    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_reset();
        rec_t e;
        sel = 0;
        do_reset();
        set_in(7'b0000011, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        e = mk(S_FETCH, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0);
        total++; if (o0 !== e) begin bad++; $display("FAIL reset_w0 got=%h exp=%h", o0, e); end
        total++; if (o2 !== e) begin bad++; $display("FAIL reset_w2 got=%h exp=%h", o2, e); end
        total++; if (on !== e) begin bad++; $display("FAIL reset_noi got=%h exp=%h", on, e); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        total++; if (o2 !== e) begin bad++; $display("FAIL release_w2 got=%h exp=%h", o2, e); end
        e = mk(S_FETCH, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0);
        total++; if (o0 !== e) begin bad++; $display("FAIL release_w0 got=%h exp=%h", o0, e); end
    endtask

    task automatic test_lw();
        sel = 0;
        do_reset();
        set_in(7'b0000011, 1'b0);
        model(7'b0000011, 1'b0);
        foreach (exp_q[k]) begin
            total++;
            if (obs !== exp_q[k]) begin bad++; $display("FAIL lw cyc=%0d got=%h exp=%h", k, obs, exp_q[k]); end
            @(posedge clk); #1;
        end
        total++;
        if (obs.st !== S_FETCH) begin bad++; $display("FAIL lw_return got=%0d exp=%0d", obs.st, S_FETCH); end
    endtask

    task automatic test_sw();
        sel = 1;
        do_reset();
        set_in(7'b0100011, 1'b0);
        model(7'b0100011, 1'b0);
        foreach (exp_q[k]) begin
            total++;
            if (obs !== exp_q[k]) begin bad++; $display("FAIL sw cyc=%0d got=%h exp=%h", k, obs, exp_q[k]); end
            @(posedge clk); #1;
        end
        total++;
        if (obs.st !== S_FETCH) begin bad++; $display("FAIL sw_return got=%0d exp=%0d", obs.st, S_FETCH); end
    endtask

    task automatic test_beq();
        sel = 0;
        do_reset();
        for (int zi = 1; zi >= 0; zi--) begin
            set_in(7'b1100011, 1'(zi));
            model(7'b1100011, 1'(zi));
            foreach (exp_q[k]) begin
                total++;
                if (obs !== exp_q[k]) begin bad++; $display("FAIL beq z=%0d cyc=%0d got=%h exp=%h", zi, k, obs, exp_q[k]); end
                @(posedge clk); #1;
            end
            total++;
            if (obs.st !== S_FETCH) begin bad++; $display("FAIL beq_return got=%0d exp=%0d", obs.st, S_FETCH); end
        end
    endtask

    task automatic test_jal_rtype();
        logic [6:0] ops [2];
        ops[0] = 7'b1101111;
        ops[1] = 7'b0110011;
        sel = 0;
        do_reset();
        foreach (ops[i]) begin
            set_in(ops[i], 1'b0);
            model(ops[i], 1'b0);
            foreach (exp_q[k]) begin
                total++;
                if (obs !== exp_q[k]) begin bad++; $display("FAIL jal_r op=%b cyc=%0d got=%h exp=%h", ops[i], k, obs, exp_q[k]); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_illegal();
        logic [6:0] ops [3];
        int         sels [3];
        ops[0] = 7'b1111111; sels[0] = 0;
        ops[1] = 7'b0010011; sels[1] = 2;
        ops[2] = 7'b1101111; sels[2] = 2;
        foreach (ops[i]) begin
            sel = sels[i];
            do_reset();
            set_in(ops[i], 1'b1);
            model(ops[i], 1'b1);
            foreach (exp_q[k]) begin
                total++;
                if (obs !== exp_q[k]) begin bad++; $display("FAIL illegal op=%b cyc=%0d got=%h exp=%h", ops[i], k, obs, exp_q[k]); end
                @(posedge clk); #1;
            end
            total++;
            if (obs.st !== S_FETCH) begin bad++; $display("FAIL illegal_return got=%0d exp=%0d", obs.st, S_FETCH); end
        end
    endtask

    task automatic test_random();
        logic [6:0] pool [8];
        logic [6:0] op;
        logic       z;
        pool[0] = 7'b0000011; pool[1] = 7'b0100011; pool[2] = 7'b0110011; pool[3] = 7'b0010011;
        pool[4] = 7'b1100011; pool[5] = 7'b1101111; pool[6] = 7'b1111111; pool[7] = 7'b0000000;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            do_reset();
            repeat (20) begin
                op = pool[$urandom_range(0, 7)];
                if ($urandom_range(0, 7) == 0) op = 7'($urandom);
                z = 1'($urandom);
                set_in(op, z);
                model(op, z);
                foreach (exp_q[k]) begin
                    total++;
                    if (obs !== exp_q[k]) begin bad++; $display("FAIL rand sel=%0d op=%b cyc=%0d got=%h exp=%h", s, op, k, obs, exp_q[k]); end
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    initial begin
        if0.Op = '0; if2.Op = '0; ifn.Op = '0;
        if0.Zero = 1'b0; if2.Zero = 1'b0; ifn.Zero = 1'b0;
        test_reset();
        test_lw();
        test_sw();
        test_beq();
        test_jal_rtype();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Control unit for the multicycle RISC-V core; replaces the purely combinational main decoder.
- Moore FSM sequences one instruction through FETCH/DECODE/execute/writeback over 3–5 cycles plus memory wait states.
- Drives the shared-memory datapath: IR, PC, ALU source muxes, result mux and register-file write enable.
- Sits between the instruction register (Op, from IR) and the existing ALU decoder (consumes ALUOp).

Parameters:
- MEM_WAIT_STATES, 0, extra cycles each memory-access state (FETCH, MEMREAD, MEMWRITE) is held; range 0..15.
- ENABLE_ITYPE, 1, 1 = opcode 0010011 (I-type ALU) supported; 0 = treated as illegal.
- ENABLE_JAL, 1, 1 = opcode 1101111 supported; 0 = treated as illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Op  in  7  opcode from the instruction register; valid from DECODE onward.
- Zero  in  1  ALU zero flag.
- PCWrite  out  1  PC register enable = PCUpdate | (Branch & Zero).
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register / OldPC enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- ImmSrc  out  2  combinational from Op: S 0100011 = 01, B 1100011 = 10, J 1101111 = 11, otherwise 00.
- IllegalOp  out  1  one-cycle pulse in DECODE when Op is unsupported.
- StateDbg  out  4  current state encoding.

Behaviour:
- Reset: async on rst = 0. State goes to FETCH and the wait counter to 0. Outputs immediately take FETCH values; IRWrite/PCWrite are gated low while rst = 0.
- Outputs are a pure decode of the registered state (and the counter where noted). Unlisted outputs are 0; ALUSrcA/B, ResultSrc and ALUOp are 00.
- FETCH: AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10. IRWrite = PCUpdate = 1 only on the final cycle (counter == MEM_WAIT_STATES). Then goes to DECODE.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (branch target). Next state by Op:
  - 0000011 / 0100011 → MEMADR.
  - 0110011 → EXECUTER.
  - 0010011 → EXECUTEI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - Anything else → FETCH with IllegalOp = 1.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Goes to MEMREAD if Op = 0000011, else MEMWRITE.
- MEMREAD: AdrSrc = 1, ResultSrc = 00, held for MEM_WAIT_STATES + 1 cycles. Then goes to MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1. Then goes to FETCH.
- MEMWRITE: AdrSrc = 1, ResultSrc = 00, MemWrite = 1 on every held cycle. Then goes to FETCH.
- EXECUTER: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10. Then goes to ALUWB.
- EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10. Then goes to ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1. Then goes to FETCH.
- BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, Branch = 1. PCWrite = Zero. Then goes to FETCH.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCUpdate = 1. Then goes to ALUWB.
- Instruction latency with W = MEM_WAIT_STATES:
  - lw: 5 + 2W cycles.
  - sw: 4 + 2W.
  - R, I, jal: 4 + W.
  - beq: 3 + W.
- Wait counter:
  - 4-bit; increments only in FETCH, MEMREAD and MEMWRITE.
  - Clears on every state exit and on entry to any other state.
  - Never exceeds MEM_WAIT_STATES, so no wrap.
  - With W = 0 the counter is unused and each memory state lasts one cycle.
- Unused state encodings go to FETCH on the next edge.
- Reset asserted mid-instruction aborts it. No partial RegWrite or MemWrite is issued after the reset edge.
- PCWrite and RegWrite are never both asserted with MemWrite.

Decomposition:
- Shared package `riscv_ctrl_pkg`:
  - Opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL).
  - State encodings S_FETCH .. S_JAL (4-bit).
  - ALUOp, ResultSrc, ALUSrcA/B and ImmSrc code constants.
- One sub-module, `imm_src_decoder`: combinational Op → ImmSrc (plus the supported-opcode check honouring the ENABLE_* parameters). It is reused by the pipelined control path.
- FSM and wait counter stay in the top module.

Test Plan:
- Reset and first fetch: hold rst = 0 for 3 cycles mid-state, release. Required response:
  - StateDbg = FETCH.
  - IRWrite = 1 and PCWrite = 1 in the first cycle after release (W = 0).
- lw sequence, W = 0, Op = 0000011. Required response:
  - States FETCH, DECODE, MEMADR, MEMREAD, MEMWB (5 cycles).
  - AdrSrc = 1 in MEMREAD.
  - RegWrite = 1 only in MEMWB with ResultSrc = 01.
- sw sequence, W = 2, Op = 0100011. Required response:
  - FETCH lasts 3 cycles with IRWrite only in the 3rd.
  - MEMWRITE lasts 3 cycles with MemWrite = 1 throughout.
  - Total 8 cycles; RegWrite never 1.
- beq, Op = 1100011. Required response:
  - With Zero = 1 in BEQ: PCWrite = 1, ALUOp = 01, ImmSrc = 10.
  - Repeated with Zero = 0: PCWrite = 0.
  - Both cases return to FETCH after 3 cycles.
- jal and R-type, Op = 1101111 then 0110011. Required response:
  - jal: JAL → ALUWB with PCWrite = 1 in JAL and ImmSrc = 11.
  - R-type: EXECUTER with ALUOp = 10, ALUSrcB = 00, then RegWrite = 1 in ALUWB.
- Illegal and disabled opcodes. Required response:
  - Op = 1111111: IllegalOp pulses once in DECODE, next state FETCH, no RegWrite, MemWrite or extra PCWrite.
  - Op = 0010011 with ENABLE_ITYPE = 0: same response.
